pc_seq_unit: RTL and testbench
==============================

// Module: pc_seq_unit
// PURPOSE
//   Parametrised program-counter sequencer; successor to the fixed 8-bit free-running PC.
//   Adds stall, absolute jump, PC-relative branch, and call/return through a hardware return-address stack.
//   Sits between control decode and instruction-memory address; o_PC drives the fetch address.
// PARAMETERS
//   PC_W        8   PC width in bits; all PC arithmetic is modulo 2**PC_W
//   STACK_DEPTH 4   return-address stack entries, >=1
//   RESET_PC    0   PC value loaded on reset, PC_W bits
// PORTS
//   i_CLK        in   1            clock, posedge active
//   i_RESET      in   1            reset, asynchronous, active-low
//   i_STALL      in   1            hold PC and stack this cycle
//   i_JUMP       in   1            absolute jump: PC <= i_TARGET
//   i_BRANCH     in   1            relative branch: PC <= PC + i_OFFSET
//   i_CALL       in   1            push PC+1, then PC <= i_TARGET
//   i_RET        in   1            PC <= popped return address
//   i_TARGET     in   PC_W         jump/call destination
//   i_OFFSET     in   PC_W         signed two's-complement branch offset
//   o_PC         out  PC_W         current PC (registered)
//   o_STACK_FULL out  1            stack holds STACK_DEPTH entries
//   o_STACK_EMPTY out 1            stack holds 0 entries
//   o_STACK_ERR  out  1            sticky: overflow or underflow has occurred
// BEHAVIOUR
//   - Reset (i_RESET=0, async): o_PC=RESET_PC, stack count=0, o_STACK_EMPTY=1, o_STACK_FULL=0, o_STACK_ERR=0.
//   - Stack entries are not cleared on reset; they are unreadable while count=0.
//   - All updates occur on posedge i_CLK; o_PC reflects the decision one cycle after the inputs are sampled.
//   - Per-cycle priority, highest first; exactly one action per cycle:
//       STALL  : PC and stack hold; all other controls ignored.
//       RET    : count>0  -> PC<=top, count--.
//                count=0  -> PC<=PC+1, ERR<=1 (underflow).
//       CALL   : count<DEPTH -> mem[count]<=PC+1, count++, PC<=i_TARGET.
//                full        -> PC<=i_TARGET, push dropped, ERR<=1 (overflow).
//       JUMP   : PC<=i_TARGET.
//       BRANCH : PC<=PC+sign_ext(i_OFFSET), i.e. modulo add of i_OFFSET.
//       none   : PC<=PC+1.
//   - Wrap-around: PC+1 at all-ones gives 0; a return address of all-ones+1 is pushed as 0.
//     Branch wraps both directions.
//   - Simultaneous CALL+RET: RET wins and CALL is ignored (no push).
//   - o_STACK_FULL = (count==STACK_DEPTH); o_STACK_EMPTY = (count==0).
//     Both are derived from the registered count, with no lag.
//   - o_STACK_ERR is cleared only by reset.
//   - Reset asserted mid-sequence aborts everything immediately (async).
//     First posedge after release: PC = RESET_PC+1 unless another control is asserted.
//   - Count register width: $clog2(STACK_DEPTH+1).
//   - No combinational path from inputs to outputs.
// STRUCTURE
//   - pc_seq_pkg:
//       typedef pc_op_e {OP_HOLD, OP_RET, OP_CALL, OP_JUMP, OP_BRANCH, OP_INC};
//       priority-encode function ctl -> pc_op_e.
//   - Top level: op decode plus PC register and next-PC mux.
//   - Sub-module pc_ret_stack: LIFO with params DEPTH, W.
//       Ports: clk, rst_n, push, pop, din, dout(top), full, empty, ovf, unf pulses.
//   - ERR flop lives in the top level, set from the ovf/unf pulses.
// TESTING (PC_W=8, STACK_DEPTH=4, RESET_PC=0)
//   1. Reset release, no controls, 257 clocks -> o_PC 01..FF,00,01; EMPTY=1 throughout.
//   2. At PC=0x10 pulse STALL 3 cycles -> PC stays 0x10; next cycle 0x11.
//      At 0x11 BRANCH OFFSET=0xFE -> 0x0F.
//      At 0x0F BRANCH OFFSET=0x05 -> 0x14.
//   3. At PC=0x20 CALL TARGET=0x80 -> PC=0x80, EMPTY=0.
//      Then 2 incs -> 0x82.
//      RET -> PC=0x21, EMPTY=1, ERR=0.
//   4. Five CALLs to 0x40,0x50,0x60,0x70,0x90 -> FULL after 4th.
//      5th: PC=0x90, ERR=1.
//      Four RETs return the 4 pushed addresses in LIFO order.
//      5th RET: PC=prev+1, ERR stays 1.
//   5. CALL+RET same cycle with count=1 (top=0x33) -> PC=0x33, count=0, no push.
//      JUMP+BRANCH same cycle -> JUMP target taken.
//   6. Assert i_RESET between clock edges with count=3, PC=0x55 -> immediately PC=0x00, EMPTY=1, ERR=0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared op encoding for the PC sequencer, plus the fixed-priority decode of the control inputs.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_RET,
    OP_CALL,
    OP_JUMP,
    OP_BRANCH,
    OP_INC
  } pc_op_e;

  // Exactly one action per cycle; an earlier test masks every later one.
  function automatic pc_op_e decode_op(input logic stall, input logic ret, input logic call,
                                       input logic jump, input logic branch);
    if (stall)  return OP_HOLD;
    if (ret)    return OP_RET;
    if (call)   return OP_CALL;
    if (jump)   return OP_JUMP;
    if (branch) return OP_BRANCH;
    return OP_INC;
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO. It pushes and pops on the next clock edge, and dout is the current top entry.
// A push when full or a pop when empty is dropped and flagged on the same-cycle ovf/unf pulse.
module pc_ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         ovf,
  output logic         unf
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_top_idx;
  logic          w_do_push;
  logic          w_do_pop;

  assign full      = (r_cnt == FULL_CNT);
  assign empty     = (r_cnt == '0);
  assign ovf       = push & full;
  assign unf       = pop & empty;
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;
  assign w_wr_idx  = AW'(r_cnt);
  assign w_top_idx = AW'(r_cnt - CW'(1));
  // Undefined while empty; the consumer must qualify dout with empty.
  assign dout      = r_mem[w_top_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_do_push) begin
      r_cnt <= r_cnt + CW'(1);
    end else if (w_do_pop) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Storage is deliberately not reset; the count alone defines validity.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[w_wr_idx] <= din;
    end
  end

endmodule

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: stall, jump, relative branch, call/return. o_PC is registered and changes one cycle after the inputs are sampled.
// The unit never blocks its inputs. Stack overflow or underflow sets the sticky o_STACK_ERR, which only reset clears.
module pc_seq_unit
  import pc_seq_pkg::*;
#(
  parameter int              PC_W        = 8,
  parameter int              STACK_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC    = '0
) (
  input  logic            i_CLK,
  input  logic            i_RESET,
  input  logic            i_STALL,
  input  logic            i_JUMP,
  input  logic            i_BRANCH,
  input  logic            i_CALL,
  input  logic            i_RET,
  input  logic [PC_W-1:0] i_TARGET,
  input  logic [PC_W-1:0] i_OFFSET,
  output logic [PC_W-1:0] o_PC,
  output logic            o_STACK_FULL,
  output logic            o_STACK_EMPTY,
  output logic            o_STACK_ERR
);

  pc_op_e          w_op;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_top;
  logic            r_err;
  logic            w_full;
  logic            w_empty;
  logic            w_ovf;
  logic            w_unf;

  assign w_op     = decode_op(i_STALL, i_RET, i_CALL, i_JUMP, i_BRANCH);
  assign w_pc_inc = r_pc + PC_W'(1);

  pc_ret_stack #(
    .DEPTH(STACK_DEPTH),
    .W    (PC_W)
  ) u_stack (
    .clk  (i_CLK),
    .rst_n(i_RESET),
    .push (w_op == OP_CALL),
    .pop  (w_op == OP_RET),
    .din  (w_pc_inc),
    .dout (w_top),
    .full (w_full),
    .empty(w_empty),
    .ovf  (w_ovf),
    .unf  (w_unf)
  );

  // The branch offset is two's complement, so a plain modulo add covers both directions.
  always_comb begin
    w_pc_nxt = w_pc_inc;
    case (w_op)
      OP_HOLD:   w_pc_nxt = r_pc;
      OP_RET:    w_pc_nxt = w_empty ? w_pc_inc : w_top;
      OP_CALL:   w_pc_nxt = i_TARGET;
      OP_JUMP:   w_pc_nxt = i_TARGET;
      OP_BRANCH: w_pc_nxt = r_pc + i_OFFSET;
      default:   w_pc_nxt = w_pc_inc;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RESET) begin
    if (!i_RESET) begin
      r_pc  <= RESET_PC;
      r_err <= 1'b0;
    end else begin
      r_pc <= w_pc_nxt;
      if (w_ovf || w_unf) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_PC          = r_pc;
  assign o_STACK_FULL  = w_full;
  assign o_STACK_EMPTY = w_empty;
  assign o_STACK_ERR   = r_err;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed bench for pc_seq_unit: each stimulus cycle queues its hand-computed result, and a monitor compares it after the clock edge.
module tb_pc_seq_unit;

  logic       i_CLK = 1'b0;
  logic       i_RESET = 1'b0;
  logic       i_STALL = 1'b0;
  logic       i_JUMP = 1'b0;
  logic       i_BRANCH = 1'b0;
  logic       i_CALL = 1'b0;
  logic       i_RET = 1'b0;
  logic [7:0] i_TARGET = '0;
  logic [7:0] i_OFFSET = '0;
  logic [7:0] o_PC;
  logic       o_STACK_FULL;
  logic       o_STACK_EMPTY;
  logic       o_STACK_ERR;

  always #5 i_CLK = ~i_CLK;

  pc_seq_unit #(.PC_W(8), .STACK_DEPTH(4), .RESET_PC(8'h00)) dut (
    .i_CLK        (i_CLK),
    .i_RESET      (i_RESET),
    .i_STALL      (i_STALL),
    .i_JUMP       (i_JUMP),
    .i_BRANCH     (i_BRANCH),
    .i_CALL       (i_CALL),
    .i_RET        (i_RET),
    .i_TARGET     (i_TARGET),
    .i_OFFSET     (i_OFFSET),
    .o_PC         (o_PC),
    .o_STACK_FULL (o_STACK_FULL),
    .o_STACK_EMPTY(o_STACK_EMPTY),
    .o_STACK_ERR  (o_STACK_ERR)
  );

  typedef struct {
    logic [7:0] pc;
    logic       full;
    logic       empty;
    logic       err;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [7:0] epc, input logic ef,
                       input logic ee, input logic eerr);
    n_total++;
    if (o_PC === epc && o_STACK_FULL === ef && o_STACK_EMPTY === ee && o_STACK_ERR === eerr) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got pc=%02h full=%b empty=%b err=%b, want pc=%02h full=%b empty=%b err=%b",
               name, o_PC, o_STACK_FULL, o_STACK_EMPTY, o_STACK_ERR, epc, ef, ee, eerr);
    end
  endtask

  // Monitor: one result per clock, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge i_CLK);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.name, e.pc, e.full, e.empty, e.err);
      end
    end
  end

  // Called at a negedge: drive one cycle of controls, queue the expectation, return at the next negedge.
  task automatic step(input string name, input logic st, input logic ret, input logic call,
                      input logic jmp, input logic br, input logic [7:0] tgt, input logic [7:0] off,
                      input logic [7:0] epc, input logic ef, input logic ee, input logic eerr);
    exp_t e;
    i_STALL = st; i_RET = ret; i_CALL = call; i_JUMP = jmp; i_BRANCH = br;
    i_TARGET = tgt; i_OFFSET = off;
    e.pc = epc; e.full = ef; e.empty = ee; e.err = eerr; e.name = name;
    sb.push_back(e);
    @(negedge i_CLK);
  endtask

  initial begin
    repeat (2) @(posedge i_CLK);
    @(negedge i_CLK);
    check("reset_state", 8'h00, 1'b0, 1'b1, 1'b0);
    i_RESET = 1'b1;

    // 1: free run across the wrap
    for (int i = 0; i < 257; i++) begin
      step("free_run", 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'((i + 1) % 256), 0, 1, 0);
    end

    // 2: stall and branches in both directions
    step("jump_10",   0, 0, 0, 1, 0, 8'h10, 8'h00, 8'h10, 0, 1, 0);
    step("stall_1",   1, 0, 0, 1, 1, 8'hEE, 8'h33, 8'h10, 0, 1, 0);
    step("stall_2",   1, 1, 1, 0, 0, 8'hEE, 8'h33, 8'h10, 0, 1, 0);
    step("stall_3",   1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h10, 0, 1, 0);
    step("post_stl",  0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h11, 0, 1, 0);
    step("br_back",   0, 0, 0, 0, 1, 8'h00, 8'hFE, 8'h0F, 0, 1, 0);
    step("br_fwd",    0, 0, 0, 0, 1, 8'h00, 8'h05, 8'h14, 0, 1, 0);

    // 3: single call/return
    step("jump_20",   0, 0, 0, 1, 0, 8'h20, 8'h00, 8'h20, 0, 1, 0);
    step("call_80",   0, 0, 1, 0, 0, 8'h80, 8'h00, 8'h80, 0, 0, 0);
    step("inc_81",    0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h81, 0, 0, 0);
    step("inc_82",    0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h82, 0, 0, 0);
    step("ret_21",    0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h21, 0, 1, 0);

    // 4: fill, overflow, drain LIFO, underflow
    step("call_40",   0, 0, 1, 0, 0, 8'h40, 8'h00, 8'h40, 0, 0, 0);
    step("call_50",   0, 0, 1, 0, 0, 8'h50, 8'h00, 8'h50, 0, 0, 0);
    step("call_60",   0, 0, 1, 0, 0, 8'h60, 8'h00, 8'h60, 0, 0, 0);
    step("call_70",   0, 0, 1, 0, 0, 8'h70, 8'h00, 8'h70, 1, 0, 0);
    step("call_ovf",  0, 0, 1, 0, 0, 8'h90, 8'h00, 8'h90, 1, 0, 1);
    step("ret_61",    0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h61, 0, 0, 1);
    step("ret_51",    0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h51, 0, 0, 1);
    step("ret_41",    0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h41, 0, 0, 1);
    step("ret_22",    0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h22, 0, 1, 1);
    step("ret_unf",   0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h23, 0, 1, 1);

    // 5: CALL+RET collision and JUMP over BRANCH
    step("jump_32",   0, 0, 0, 1, 0, 8'h32, 8'h00, 8'h32, 0, 1, 1);
    step("call_push", 0, 0, 1, 0, 0, 8'h70, 8'h00, 8'h70, 0, 0, 1);
    step("call_ret",  0, 1, 1, 0, 0, 8'h99, 8'h00, 8'h33, 0, 1, 1);
    step("no_push",   0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h34, 0, 1, 1);
    step("jmp_br",    0, 0, 0, 1, 1, 8'hA0, 8'h10, 8'hA0, 0, 1, 1);

    // 6: async reset mid-cycle with three entries stacked
    step("jump_50",   0, 0, 0, 1, 0, 8'h50, 8'h00, 8'h50, 0, 1, 1);
    step("call_51",   0, 0, 1, 0, 0, 8'h51, 8'h00, 8'h51, 0, 0, 1);
    step("call_52",   0, 0, 1, 0, 0, 8'h52, 8'h00, 8'h52, 0, 0, 1);
    step("call_55",   0, 0, 1, 0, 0, 8'h55, 8'h00, 8'h55, 0, 0, 1);
    #2;
    i_RESET = 1'b0;
    i_CALL = 1'b0;
    #1;
    check("async_rst", 8'h00, 1'b0, 1'b1, 1'b0);
    @(negedge i_CLK);
    i_RESET = 1'b1;
    step("post_rst",  0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h01, 0, 1, 0);
    step("rst_unf",   0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h02, 0, 1, 1);
    step("idle",      0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h03, 0, 1, 1);

    @(negedge i_CLK);
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
